dmem_ctrl: RTL and testbench
============================

# dmem_ctrl

Word-wide data-memory controller that sits directly downstream of the load/store unit and serves its `d_*` request/ready interface. It holds an internal word-addressed RAM and completes each read or write after a programmable number of wait states. It raises an error on out-of-range addresses. Its wait-state count lets the core be exercised against slow memory without an external bus model.

## Interface
- `DEPTH`, 1024: RAM size in 32-bit words; power of two, 16..65536; `AW = $clog2(DEPTH)`.
- `WAIT_CYCLES`, 1: extra cycles between request capture and completion; legal range 0..15.
- `clk` in 1: single clock; all logic on rising edge.
- `rstb` in 1: asynchronous reset, active-high.
- `d_addr` in 32: byte address; `d_addr[1:0]` ignored; word index is `d_addr[AW+1:2]`.
- `d_wr_data` in 32: write data.
- `d_wr_req` in 1: write request, held with stable address and data until `d_wr_ready`.
- `d_wr_ready` out 1: one-cycle write-completion pulse.
- `d_rd_req` in 1: read request, held with stable address until `d_rd_ready`.
- `d_rd_ready` out 1: one-cycle read-completion pulse; `d_rd_data` is valid in that cycle.
- `d_rd_data` out 32: read data, held until the next read completes.
- `d_err` out 1: pulses together with a ready when the completed access was out of range.

## Operation
- FSM states:
  - IDLE: sample the requests.
  - WAIT: count down the wait states.
  - RESP: drive the one-cycle ready pulse.
- IDLE, `d_wr_req`=1: capture address/data and set op=WR. `d_wr_req` has priority over `d_rd_req` when both are high.
- IDLE, `d_rd_req`=1 only: capture the address and set op=RD.
- After capture: load `cnt=WAIT_CYCLES`. Go to WAIT if `cnt>0`, otherwise commit immediately and go to RESP.
- WAIT: decrement `cnt`. On the edge where `cnt` goes 1→0, commit and go to RESP.
- Commit, WR in range: `mem[idx] <= wdata`.
- Commit, RD in range: `d_rd_data <= mem[idx]`.
- Out of range means `d_addr[31:AW+2] != 0`:
  - Writes are dropped.
  - Reads load `d_rd_data = 0`.
  - `d_err` is raised in the RESP cycle.
- RESP: assert exactly one of `d_wr_ready`/`d_rd_ready` (per op) for one cycle, then return to IDLE.
- Requester rule: deassert (or change) the request in the cycle after ready. A request still high in IDLE is treated as a new access.
- Simultaneous WR+RD held: the write completes first. The read is captured in the IDLE cycle after RESP, and returns the newly written data if the address matches.
- Request inputs are ignored in WAIT/RESP. Changing address or data mid-access has no effect, because they were captured at IDLE.
- Reset:
  - Asynchronous; the FSM goes to IDLE and `cnt`=0.
  - `d_wr_ready`, `d_rd_ready`, `d_err` = 0 and `d_rd_data` = 0.
  - RAM contents are not reset and keep their values across reset.
  - Reset before the commit edge aborts the access with no RAM update.

## Timing
- Request first high in IDLE at cycle N: ready pulse is in cycle N+1+WAIT_CYCLES.
- Fastest back-to-back: the next request is sampled in cycle N+2+WAIT_CYCLES. One access takes WAIT_CYCLES+2 cycles.
- `d_rd_data` changes only on a read-commit edge, so it is valid in the `d_rd_ready` cycle.
- All outputs are registered, with no combinational path from inputs to outputs.
- RAM read is synchronous, one read port and one write port. An array is inferred, not flops with reset.

## Test plan
- Reset with WAIT_CYCLES=1: all outputs 0. Write 0xDEADBEEF at 0x10 with the request at cycle N: `d_wr_ready` pulses in cycle N+2 only, and `d_err`=0.
- Read 0x10, then read 0x13: both return 0xDEADBEEF with a single `d_rd_ready` pulse each. `d_rd_data` holds the value after the pulse.
- WAIT_CYCLES=0 and WAIT_CYCLES=15 builds, 8 back-to-back alternating writes/reads: ready arrives at N+1 and N+16 respectively. Throughput is one access per WAIT_CYCLES+2 cycles, and all data matches.
- DEPTH=1024, write 0x12345678 to 0x1000 (out of range): `d_wr_ready`=1 and `d_err`=1 in the same cycle. Then a read of 0x0000 returns the prior value, and a read of 0x1000 returns 0 with `d_err`=1.
- `d_wr_req` and `d_rd_req` both high at 0x20, wdata 0xA5A5A5A5: write completes first, then the read completes with 0xA5A5A5A5. Ready pulses never overlap.
- WAIT_CYCLES=4, write 0x11 to 0x40 followed by write 0x22 to 0x40; assert `rstb` two cycles into the second write: outputs go to 0 immediately, and a read of 0x40 after reset returns 0x11.

Source files
------------

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: word-wide data memory behind the load/store unit's d_* interface.
// Each access is captured in IDLE, optionally delayed by WAIT_CYCLES wait
// states, committed to (or read from) the internal RAM, then acknowledged
// with a one-cycle ready pulse. Addresses beyond the RAM raise d_err.
module dmem_ctrl #(
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rstb,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wr_data,
    input  logic        d_wr_req,
    output logic        d_wr_ready,
    input  logic        d_rd_req,
    output logic        d_rd_ready,
    output logic [31:0] d_rd_data,
    output logic        d_err
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES);

    // Captured access: word address (byte offset dropped), op and write data.
    typedef struct packed {
        logic        wr;
        logic [29:0] word;
        logic [31:0] data;
    } req_t;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    logic [31:0] mem [DEPTH];

    state_t       state;
    logic [3:0]   cnt;
    req_t         req_q;
    req_t         req_in;
    req_t         acc;
    logic         req_any;
    logic         commit;
    logic         in_range;
    logic [AW-1:0] idx;
    logic         addr_lsb_unused;

    // Byte offset within the word carries no meaning for a word memory.
    assign addr_lsb_unused = ^d_addr[1:0];

    // Incoming request as it would be captured this cycle; write wins a tie.
    always_comb begin
        req_in.wr   = d_wr_req;
        req_in.word = d_addr[31:2];
        req_in.data = d_wr_data;
    end

    assign req_any = d_wr_req | d_rd_req;

    // With zero wait states the commit happens on the capture edge, so the
    // access being committed is the live request rather than the captured one.
    assign acc      = (state == S_IDLE) ? req_in : req_q;
    assign idx      = acc.word[AW-1:0];
    assign in_range = (acc.word[29:AW] == '0);
    assign commit   = ((state == S_IDLE) && req_any && (WAIT_CYCLES == 0)) ||
                      ((state == S_WAIT) && (cnt == 4'd1));

    // RAM write port: no reset so an array is inferred; reset blocks a commit.
    always_ff @(posedge clk) begin
        if (commit && acc.wr && in_range && !rstb)
            mem[idx] <= acc.data;
    end

    // Access sequencer: capture, count wait states, commit and acknowledge.
    always_ff @(posedge clk or posedge rstb) begin
        if (rstb) begin
            state      <= S_IDLE;
            cnt        <= '0;
            req_q      <= '0;
            d_wr_ready <= 1'b0;
            d_rd_ready <= 1'b0;
            d_err      <= 1'b0;
            d_rd_data  <= '0;
        end else begin
            d_wr_ready <= 1'b0;
            d_rd_ready <= 1'b0;
            d_err      <= 1'b0;

            unique case (state)
                S_IDLE: begin
                    if (req_any) begin
                        req_q <= req_in;
                        cnt   <= CNT_INIT;
                        state <= (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
                    end
                end
                S_WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1)
                        state <= S_RESP;
                end
                S_RESP: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase

            // Ready and error are registered on the commit edge so they
            // appear together in the RESP cycle.
            if (commit) begin
                d_wr_ready <= acc.wr;
                d_rd_ready <= !acc.wr;
                d_err      <= !in_range;
                if (!acc.wr)
                    d_rd_data <= in_range ? mem[idx] : 32'h0;
            end
        end
    end
endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: four instances with different wait-state counts,
// driven from a table of directed accesses plus hand-written corner cases.
module tb_dmem_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst     [4];
    logic [31:0] addr    [4];
    logic [31:0] wdata   [4];
    logic [31:0] rdata   [4];
    logic        wr_req  [4];
    logic        rd_req  [4];
    logic        wr_rdy  [4];
    logic        rd_rdy  [4];
    logic        err     [4];
    logic [31:0] last_rd [4];

    int checks = 0;
    int errors = 0;

    function automatic int wc(input int k);
        case (k)
            0: return 1;
            1: return 0;
            2: return 15;
            default: return 4;
        endcase
    endfunction

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int W = (g == 0) ? 1 : (g == 1) ? 0 : (g == 2) ? 15 : 4;
        dmem_ctrl #(.DEPTH(1024), .WAIT_CYCLES(W)) u_dut (
            .clk        (clk),
            .rstb       (rst[g]),
            .d_addr     (addr[g]),
            .d_wr_data  (wdata[g]),
            .d_wr_req   (wr_req[g]),
            .d_wr_ready (wr_rdy[g]),
            .d_rd_req   (rd_req[g]),
            .d_rd_ready (rd_rdy[g]),
            .d_rd_data  (rdata[g]),
            .d_err      (err[g])
        );
    end

    typedef struct {
        int          k;
        bit          wr;
        logic [31:0] a;
        logic [31:0] wd;
        bit          xerr;
        logic [31:0] xrd;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input int k, input bit wr, input logic [31:0] a,
                                input logic [31:0] wd, input bit xerr, input logic [31:0] xrd);
        vec_t v;
        v.k = k; v.wr = wr; v.a = a; v.wd = wd; v.xerr = xerr; v.xrd = xrd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    // One access: raise the request now, wait for ready, check latency and
    // response, then drop the request right after the RESP edge.
    task automatic do_vec(input vec_t v, input string tag);
        int n;
        bit seen;
        wr_req[v.k] = v.wr;
        rd_req[v.k] = !v.wr;
        addr[v.k]   = v.a;
        wdata[v.k]  = v.wd;
        seen = 0;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i == 0) chk({tag, " hold"}, rdata[v.k], last_rd[v.k]);
            if (wr_rdy[v.k] || rd_rdy[v.k]) begin
                n = i;
                seen = 1;
                break;
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: no ready within 40 cycles", tag);
        end else begin
            chk({tag, " latency"},  32'(n), 32'(1 + wc(v.k)));
            chk({tag, " wr_ready"}, 32'(wr_rdy[v.k]), 32'(v.wr));
            chk({tag, " rd_ready"}, 32'(rd_rdy[v.k]), 32'(!v.wr));
            chk({tag, " err"},      32'(err[v.k]), 32'(v.xerr));
            if (!v.wr) begin
                chk({tag, " rd_data"}, rdata[v.k], v.xrd);
                last_rd[v.k] = v.xrd;
            end
        end
        @(posedge clk); #1;
        wr_req[v.k] = 1'b0;
        rd_req[v.k] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int wr_n, rd_n;
        bit ovl;
        logic [31:0] got;
        logic gerr;

        for (int k = 0; k < 4; k++) begin
            rst[k] = 1'b1; addr[k] = '0; wdata[k] = '0;
            wr_req[k] = 1'b0; rd_req[k] = 1'b0; last_rd[k] = '0;
        end

        // Single accesses; consecutive entries for one instance run back-to-back.
        vecs.push_back(mk(0, 1, 32'h10,       32'hDEADBEEF, 0, 0));
        vecs.push_back(mk(0, 0, 32'h10,       0,            0, 32'hDEADBEEF));
        vecs.push_back(mk(0, 0, 32'h13,       0,            0, 32'hDEADBEEF));
        vecs.push_back(mk(0, 1, 32'h0,        32'hCAFEF00D, 0, 0));
        vecs.push_back(mk(0, 1, 32'h1000,     32'h12345678, 1, 0));
        vecs.push_back(mk(0, 0, 32'h0,        0,            0, 32'hCAFEF00D));
        vecs.push_back(mk(0, 0, 32'h1000,     0,            1, 32'h0));
        vecs.push_back(mk(0, 0, 32'h10,       0,            0, 32'hDEADBEEF));
        vecs.push_back(mk(0, 0, 32'h80000010, 0,            1, 32'h0));
        vecs.push_back(mk(1, 1, 32'h100, 32'h11111111, 0, 0));
        vecs.push_back(mk(1, 0, 32'h100, 0,            0, 32'h11111111));
        vecs.push_back(mk(1, 1, 32'h104, 32'h22222222, 0, 0));
        vecs.push_back(mk(1, 0, 32'h104, 0,            0, 32'h22222222));
        vecs.push_back(mk(1, 1, 32'hFFC, 32'h33333333, 0, 0));
        vecs.push_back(mk(1, 0, 32'hFFE, 0,            0, 32'h33333333));
        vecs.push_back(mk(1, 1, 32'h108, 32'h44444444, 0, 0));
        vecs.push_back(mk(1, 0, 32'h100, 0,            0, 32'h11111111));
        vecs.push_back(mk(2, 1, 32'h200, 32'h000000A1, 0, 0));
        vecs.push_back(mk(2, 0, 32'h200, 0,            0, 32'h000000A1));
        vecs.push_back(mk(2, 1, 32'h204, 32'h000000B2, 0, 0));
        vecs.push_back(mk(2, 0, 32'h204, 0,            0, 32'h000000B2));
        vecs.push_back(mk(2, 1, 32'h3FC, 32'h000000C3, 0, 0));
        vecs.push_back(mk(2, 0, 32'h3FC, 0,            0, 32'h000000C3));
        vecs.push_back(mk(2, 1, 32'h200, 32'h000000D4, 0, 0));
        vecs.push_back(mk(2, 0, 32'h200, 0,            0, 32'h000000D4));
        vecs.push_back(mk(3, 1, 32'h40,  32'h00000011, 0, 0));
        vecs.push_back(mk(3, 0, 32'h40,  0,            0, 32'h00000011));

        // Reset state of every instance.
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("reset%0d wr_ready", k), 32'(wr_rdy[k]), 0);
            chk($sformatf("reset%0d rd_ready", k), 32'(rd_rdy[k]), 0);
            chk($sformatf("reset%0d err", k),      32'(err[k]), 0);
            chk($sformatf("reset%0d rd_data", k),  rdata[k], 0);
        end
        @(posedge clk); #1;
        for (int k = 0; k < 4; k++) rst[k] = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < vecs.size(); i++)
            do_vec(vecs[i], $sformatf("v%0d", i));

        // Write and read held together: write first, read one access later.
        wr_req[0] = 1'b1; rd_req[0] = 1'b1;
        addr[0] = 32'h20; wdata[0] = 32'hA5A5A5A5;
        wr_n = -1; rd_n = -1; ovl = 0; got = '0; gerr = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (wr_rdy[0] && rd_rdy[0]) ovl = 1;
            if (wr_rdy[0] && wr_n < 0) wr_n = i;
            if (rd_rdy[0]) begin
                rd_n = i; got = rdata[0]; gerr = err[0];
                break;
            end
            @(posedge clk); #1;
            if (wr_n >= 0) wr_req[0] = 1'b0;
        end
        @(posedge clk); #1;
        wr_req[0] = 1'b0; rd_req[0] = 1'b0;
        chk("both overlap",   32'(ovl), 0);
        chk("both wr cycle",  32'(wr_n), 2);
        chk("both rd cycle",  32'(rd_n), 5);
        chk("both rd_data",   got, 32'hA5A5A5A5);
        chk("both err",       32'(gerr), 0);
        repeat (3) @(negedge clk);
        chk("both hold", rdata[0], 32'hA5A5A5A5);

        // Reset two cycles into a WAIT_CYCLES=4 write aborts it.
        @(posedge clk); #1;
        wr_req[3] = 1'b1; addr[3] = 32'h40; wdata[3] = 32'h22;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst[3] = 1'b1;
        #1;
        chk("abort wr_ready", 32'(wr_rdy[3]), 0);
        chk("abort rd_ready", 32'(rd_rdy[3]), 0);
        chk("abort err",      32'(err[3]), 0);
        chk("abort rd_data",  rdata[3], 0);
        wr_req[3] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst[3] = 1'b0;
        last_rd[3] = '0;
        @(posedge clk); #1;
        do_vec(mk(3, 0, 32'h40, 0, 0, 32'h00000011), "abort readback");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
